// File: rtl/tile_scheduler_pkg.sv
// Shared types and timing helpers for the systolic-array tile scheduler.
package tile_scheduler_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_W = 3'd1,
      STREAM = 3'd2,
      DRAIN  = 3'd3,
      FINISH = 3'd4
   } sched_state_t;

   localparam int SYS_ROWS_DEF = 2;
   localparam int SYS_COLS_DEF = 2;
   localparam int SCHED_LAT    = SYS_ROWS_DEF + SYS_COLS_DEF - 1;

   // Array fill/flush latency from first A row in to first result row out.
   function automatic int sched_lat(input int sys_rows, input int sys_cols);
      return sys_rows + sys_cols - 1;
   endfunction

endpackage

// File: rtl/tile_scheduler_delay_line.sv
// Fixed-depth valid+payload shift register aligning accumulator writes with array output.
module tile_delay_line #(
   parameter int LAT = 3,
   parameter int PW  = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [PW-1:0] in_payload,
   output logic          out_valid,
   output logic [PW-1:0] out_payload
);

   logic [LAT-1:0] vld_q;
   logic [PW-1:0]  pay_q [LAT];

   // Shift valid and payload one stage per cycle; reset clears every stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= {LAT{1'b0}};
         for (int s = 0; s < LAT; s++) begin
            pay_q[s] <= {PW{1'b0}};
         end
      end else begin
         for (int s = LAT - 1; s > 0; s--) begin
            vld_q[s] <= vld_q[s-1];
            pay_q[s] <= pay_q[s-1];
         end
         vld_q[0] <= in_valid;
         pay_q[0] <= in_payload;
      end
   end

   assign out_valid   = vld_q[LAT-1];
   assign out_payload = pay_q[LAT-1];

endmodule

// File: rtl/tile_scheduler.sv
// Sequences one tiled matrix multiply on the systolic array (k inner, n outer).
// Optional TILE_SCHED_PERF_EN adds perf_cycles/perf_stall counters.
module tile_scheduler
   import tile_scheduler_pkg::*;
#(
   parameter int SYS_ROWS = 2,
   parameter int SYS_COLS = 2,
   parameter int W_DEPTH  = 16,
   parameter int A_DEPTH  = 16,
   parameter int DIM_W    = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [DIM_W-1:0]           m_rows,
   input  logic [DIM_W-1:0]           k_tiles,
   input  logic [DIM_W-1:0]           n_tiles,
   output logic                       busy,
   output logic                       done,
   output logic                       cfg_err,
   output logic                       w_rd_en,
   output logic [$clog2(W_DEPTH)-1:0] w_rd_addr,
   output logic                       w_load,
   output logic                       a_rd_en,
   output logic [$clog2(A_DEPTH)-1:0] a_rd_addr,
   output logic                       acc_wr_en,
   output logic [$clog2(A_DEPTH)-1:0] acc_addr,
   output logic                       acc_first,
   output logic                       acc_last,
   output logic [DIM_W-1:0]           tile_n
`ifdef TILE_SCHED_PERF_EN
   ,
   output logic [31:0]                perf_cycles,
   output logic [31:0]                perf_stall
`endif
);

   localparam int LAT = sched_lat(SYS_ROWS, SYS_COLS);
   localparam int WAW = $clog2(W_DEPTH);
   localparam int AAW = $clog2(A_DEPTH);
   localparam int PW  = AAW + 2;
   localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

   sched_state_t     state_q, state_d;
   logic [DIM_W-1:0] cnt_q, cnt_d;
   logic [DIM_W-1:0] k_q, k_d;
   logic [DIM_W-1:0] n_q, n_d;
   logic [DIM_W-1:0] m_cfg_q, m_cfg_d;
   logic [DIM_W-1:0] kt_q, kt_d;
   logic [DIM_W-1:0] nt_q, nt_d;
   logic             cfg_err_q, cfg_err_d;
   logic             w_load_q;
   logic             cfg_bad_s;
   logic             accept_s;
   logic [PW-1:0]    acc_payload_s;
   logic [PW-1:0]    acc_payload_out_s;

   assign cfg_bad_s = (m_rows == {DIM_W{1'b0}}) || (k_tiles == {DIM_W{1'b0}}) ||
                      (n_tiles == {DIM_W{1'b0}}) || (32'(m_rows) > 32'(A_DEPTH)) ||
                      ((32'(k_tiles) * 32'(n_tiles) * 32'(SYS_ROWS)) > 32'(W_DEPTH));
   assign accept_s  = (state_q == IDLE) && start && !cfg_bad_s;

   // State, counters and latched job dimensions.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= {DIM_W{1'b0}};
         k_q       <= {DIM_W{1'b0}};
         n_q       <= {DIM_W{1'b0}};
         m_cfg_q   <= {DIM_W{1'b0}};
         kt_q      <= {DIM_W{1'b0}};
         nt_q      <= {DIM_W{1'b0}};
         cfg_err_q <= 1'b0;
         w_load_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         k_q       <= k_d;
         n_q       <= n_d;
         m_cfg_q   <= m_cfg_d;
         kt_q      <= kt_d;
         nt_q      <= nt_d;
         cfg_err_q <= cfg_err_d;
         w_load_q  <= w_rd_en;
      end
   end

   // Next-state logic: per-phase cycle counter, k inner / n outer tile walk.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      k_d       = k_q;
      n_d       = n_q;
      m_cfg_d   = m_cfg_q;
      kt_d      = kt_q;
      nt_d      = nt_q;
      cfg_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && cfg_bad_s) begin
               cfg_err_d = 1'b1;
            end else if (accept_s) begin
               m_cfg_d = m_rows;
               kt_d    = k_tiles;
               nt_d    = n_tiles;
               cnt_d   = {DIM_W{1'b0}};
               k_d     = {DIM_W{1'b0}};
               n_d     = {DIM_W{1'b0}};
               state_d = LOAD_W;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD_W: begin
            if (cnt_q == DIM_W'(SYS_ROWS - 1)) begin
               cnt_d   = {DIM_W{1'b0}};
               state_d = STREAM;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         STREAM: begin
            if (cnt_q == (m_cfg_q - ONE)) begin
               cnt_d   = {DIM_W{1'b0}};
               state_d = DRAIN;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         DRAIN: begin
            if (cnt_q == DIM_W'(LAT - 1)) begin
               cnt_d = {DIM_W{1'b0}};
               if (k_q != (kt_q - ONE)) begin
                  k_d     = k_q + ONE;
                  state_d = LOAD_W;
               end else if (n_q != (nt_q - ONE)) begin
                  k_d     = {DIM_W{1'b0}};
                  n_d     = n_q + ONE;
                  state_d = LOAD_W;
               end else begin
                  k_d     = {DIM_W{1'b0}};
                  n_d     = {DIM_W{1'b0}};
                  state_d = FINISH;
               end
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Buffer read strobes and addresses, decoded from the current phase only.
   always_comb begin
      w_rd_en       = 1'b0;
      w_rd_addr     = {WAW{1'b0}};
      a_rd_en       = 1'b0;
      a_rd_addr     = {AAW{1'b0}};
      acc_payload_s = {PW{1'b0}};
      if (state_q == LOAD_W) begin
         w_rd_en   = 1'b1;
         w_rd_addr = WAW'((32'(n_q) * 32'(kt_q) + 32'(k_q)) * 32'(SYS_ROWS) + 32'(cnt_q));
      end else if (state_q == STREAM) begin
         a_rd_en       = 1'b1;
         a_rd_addr     = AAW'((32'(k_q) * 32'(m_cfg_q) + 32'(cnt_q)) % 32'(A_DEPTH));
         acc_payload_s = {AAW'(cnt_q), (k_q == {DIM_W{1'b0}}), (k_q == (kt_q - ONE))};
      end else begin
         w_rd_en = 1'b0;
      end
   end

   tile_delay_line #(
      .LAT (LAT),
      .PW  (PW)
   ) u_acc_delay (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (a_rd_en),
      .in_payload  (acc_payload_s),
      .out_valid   (acc_wr_en),
      .out_payload (acc_payload_out_s)
   );

   assign acc_addr  = acc_payload_out_s[PW-1:2];
   assign acc_first = acc_payload_out_s[1];
   assign acc_last  = acc_payload_out_s[0];
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == FINISH);
   assign cfg_err   = cfg_err_q;
   assign w_load    = w_load_q;
   assign tile_n    = n_q;

`ifdef TILE_SCHED_PERF_EN
   logic [31:0] perf_cycles_q;
   logic [31:0] perf_stall_q;

   // Busy and stall counters: cleared on acceptance, frozen once back in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_cycles_q <= 32'd0;
         perf_stall_q  <= 32'd0;
      end else if (accept_s) begin
         perf_cycles_q <= 32'd0;
         perf_stall_q  <= 32'd0;
      end else if (state_q != IDLE) begin
         perf_cycles_q <= perf_cycles_q + 32'd1;
         if ((state_q == LOAD_W) || (state_q == DRAIN)) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   assign perf_cycles = perf_cycles_q;
   assign perf_stall  = perf_stall_q;
`endif

endmodule
